lm32_tlb_ctrl: RTL and testbench

Direct-mapped translation controller that drives the lm32 dual-port entry RAM and consumes its read data. It issues lookups on the RAM read port and compares the returned tag, producing pipelined hit/miss and PPN results. It owns the RAM write port for refill, single-entry invalidate and full flush. A flush sweep runs after every reset, because the RAM's contents are not guaranteed in hardware.

---
 rtl/lm32_tlb_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lm32_tlb_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm32_tlb_ctrl.sv
// Direct-mapped translation controller for the lm32 dual-port entry RAM.
// Issues lookups, compares returned tags, and owns the write port for refill, invalidate and flush.
module lm32_tlb_ctrl #(
  parameter int vpn_width   = 20,
  parameter int index_width = 10,
  parameter int ppn_width   = 20,
  localparam int tag_width  = vpn_width - index_width,
  localparam int ew         = 1 + tag_width + ppn_width
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   lookup_stb_i,
  input  logic [vpn_width-1:0]   lookup_vpn_i,
  input  logic                   upd_stb_i,
  input  logic [vpn_width-1:0]   upd_vpn_i,
  input  logic [ppn_width-1:0]   upd_ppn_i,
  input  logic                   inv_stb_i,
  input  logic [vpn_width-1:0]   inv_vpn_i,
  input  logic                   flush_stb_i,
  output logic                   busy_o,
  output logic                   lookup_done_o,
  output logic                   hit_o,
  output logic [ppn_width-1:0]   ppn_o,
  output logic [31:0]            hit_cnt_o,
  output logic [31:0]            miss_cnt_o,
  output logic                   ram_we_o,
  output logic [index_width-1:0] ram_waddr_o,
  output logic [ew-1:0]          ram_wdata_o,
  output logic [index_width-1:0] ram_raddr_o,
  input  logic [ew-1:0]          ram_rdata_i
);

  typedef enum logic {FLUSH, RUN} state_e;

  state_e                 state_q, state_d;
  logic [index_width-1:0] sweep_q, sweep_d;

  logic                   we_c;
  logic [index_width-1:0] waddr_c;
  logic [ew-1:0]          wdata_c;
  logic [index_width-1:0] raddr_c;
  logic                   clr_cnt_c;

  logic                   s1_valid_q, s1_valid_d;
  logic [tag_width-1:0]   s1_tag_q, s1_tag_d;
  logic                   s1_fwd_q, s1_fwd_d;
  logic [ew-1:0]          s1_fwd_data_q, s1_fwd_data_d;

  logic                   done_q;
  logic                   hit_q, hit_d;
  logic [ppn_width-1:0]   ppn_q, ppn_d;
  logic [31:0]            hit_cnt_q, hit_cnt_d;
  logic [31:0]            miss_cnt_q, miss_cnt_d;
  logic [31:0]            hit_base, miss_base;

  logic [index_width-1:0] lookup_idx, upd_idx, inv_idx;
  logic [ew-1:0]          s1_entry;
  logic                   s1_hit;
  logic                   unused_inv_tag;

  assign lookup_idx     = lookup_vpn_i[index_width-1:0];
  assign upd_idx        = upd_vpn_i[index_width-1:0];
  assign inv_idx        = inv_vpn_i[index_width-1:0];
  assign unused_inv_tag = ^inv_vpn_i[vpn_width-1:index_width];

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    we_c      = 1'b0;
    waddr_c   = '0;
    wdata_c   = '0;
    raddr_c   = '0;
    clr_cnt_c = 1'b0;
    case (state_q)
      FLUSH: begin
        we_c    = 1'b1;
        waddr_c = sweep_q;
        sweep_d = sweep_q + index_width'(1);
        if (sweep_q == '1) state_d = RUN;
      end
      RUN: begin
        raddr_c = lookup_idx;
        // Flush outranks invalidate, which outranks refill; only one write per cycle.
        if (flush_stb_i) begin
          state_d   = FLUSH;
          sweep_d   = '0;
          clr_cnt_c = 1'b1;
        end else if (inv_stb_i) begin
          we_c    = 1'b1;
          waddr_c = inv_idx;
        end else if (upd_stb_i) begin
          we_c    = 1'b1;
          waddr_c = upd_idx;
          wdata_c = {1'b1, upd_vpn_i[vpn_width-1:index_width], upd_ppn_i};
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  assign busy_o      = (state_q == FLUSH);
  assign ram_we_o    = we_c && !rst_i;
  assign ram_waddr_o = rst_i ? '0 : waddr_c;
  assign ram_wdata_o = rst_i ? '0 : wdata_c;
  assign ram_raddr_o = rst_i ? '0 : raddr_c;

  // The RAM returns old data on a same-cycle read/write collision, so such a write is forwarded.
  always_comb begin
    s1_valid_d    = (state_q == RUN) && lookup_stb_i;
    s1_tag_d      = lookup_vpn_i[vpn_width-1:index_width];
    s1_fwd_d      = s1_valid_d && we_c && (waddr_c == lookup_idx);
    s1_fwd_data_d = wdata_c;
  end

  assign s1_entry = s1_fwd_q ? s1_fwd_data_q : ram_rdata_i;
  assign s1_hit   = s1_entry[ew-1] && (s1_entry[ew-2:ppn_width] == s1_tag_q);

  always_comb begin
    hit_d      = s1_valid_q && s1_hit;
    ppn_d      = (s1_valid_q && s1_hit) ? s1_entry[ppn_width-1:0] : '0;
    hit_base   = clr_cnt_c ? '0 : hit_cnt_q;
    miss_base  = clr_cnt_c ? '0 : miss_cnt_q;
    hit_cnt_d  = hit_base;
    miss_cnt_d = miss_base;
    if (s1_valid_q && s1_hit && (hit_base != '1)) hit_cnt_d = hit_base + 32'd1;
    if (s1_valid_q && !s1_hit && (miss_base != '1)) miss_cnt_d = miss_base + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= FLUSH;
      sweep_q       <= '0;
      s1_valid_q    <= 1'b0;
      s1_tag_q      <= '0;
      s1_fwd_q      <= 1'b0;
      s1_fwd_data_q <= '0;
      done_q        <= 1'b0;
      hit_q         <= 1'b0;
      ppn_q         <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      s1_valid_q    <= s1_valid_d;
      s1_tag_q      <= s1_tag_d;
      s1_fwd_q      <= s1_fwd_d;
      s1_fwd_data_q <= s1_fwd_data_d;
      done_q        <= s1_valid_q;
      hit_q         <= hit_d;
      ppn_q         <= ppn_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  assign lookup_done_o = done_q;
  assign hit_o         = hit_q;
  assign ppn_o         = ppn_q;
  assign hit_cnt_o     = hit_cnt_q;
  assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_lm32_tlb_ctrl.sv
// Scoreboard bench for lm32_tlb_ctrl: a behavioural entry table predicts every lookup result,
// and a read-old RAM model sits on the controller's RAM ports.
module tb_lm32_tlb_ctrl;
  localparam int VW = 20;
  localparam int IW = 10;
  localparam int PW = 20;
  localparam int EW = 31;
  localparam int DEPTH = 1024;

  logic clock;
  logic reset;
  logic lookupStb, updStb, invStb, flushStb;
  logic [VW-1:0] lookupVpn, updVpn, invVpn;
  logic [PW-1:0] updPpn;
  logic busy, lookupDone, hit;
  logic [PW-1:0] ppn;
  logic [31:0] hitCnt, missCnt;
  logic ramWe;
  logic [IW-1:0] ramWaddr, ramRaddr;
  logic [EW-1:0] ramWdata, ramRdata;

  typedef struct {
    logic          hit;
    logic [PW-1:0] ppn;
    int            cyc;
  } expect_t;

  expect_t expQ[$];
  expect_t monEntry;
  logic refValid [DEPTH];
  logic [VW-IW-1:0] refTag [DEPTH];
  logic [PW-1:0] refPpn [DEPTH];
  logic [EW-1:0] ramArray [DEPTH];
  logic [31:0] expHitCnt, expMissCnt;
  int checkCount, errorCount, cycleCount;

  lm32_tlb_ctrl dut (
    .clk_i(clock), .rst_i(reset),
    .lookup_stb_i(lookupStb), .lookup_vpn_i(lookupVpn),
    .upd_stb_i(updStb), .upd_vpn_i(updVpn), .upd_ppn_i(updPpn),
    .inv_stb_i(invStb), .inv_vpn_i(invVpn), .flush_stb_i(flushStb),
    .busy_o(busy), .lookup_done_o(lookupDone), .hit_o(hit), .ppn_o(ppn),
    .hit_cnt_o(hitCnt), .miss_cnt_o(missCnt),
    .ram_we_o(ramWe), .ram_waddr_o(ramWaddr), .ram_wdata_o(ramWdata),
    .ram_raddr_o(ramRaddr), .ram_rdata_i(ramRdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    cycleCount <= cycleCount + 1;
    if (ramWe) ramArray[ramWaddr] <= ramWdata;
    ramRdata <= ramArray[ramRaddr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, observed, expected, cycleCount);
    end
  endtask

  function automatic void clearModel();
    for (int i = 0; i < DEPTH; i++) begin
      refValid[i] = 1'b0;
      refTag[i]   = '0;
      refPpn[i]   = '0;
    end
  endfunction

  // Results are popped in order; counters are predicted including the current done pulse.
  always @(negedge clock) begin
    if (lookupDone === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 64'd1, 64'd0);
      end else begin
        monEntry = expQ.pop_front();
        if (monEntry.hit) begin
          if (expHitCnt != 32'hFFFF_FFFF) expHitCnt = expHitCnt + 32'd1;
        end else begin
          if (expMissCnt != 32'hFFFF_FFFF) expMissCnt = expMissCnt + 32'd1;
        end
        checkOutput("latency", 64'(cycleCount - monEntry.cyc), 64'd2);
        checkOutput("hit", 64'(hit), 64'(monEntry.hit));
        checkOutput("ppn", 64'(ppn), 64'(monEntry.ppn));
        checkOutput("hitCnt", 64'(hitCnt), 64'(expHitCnt));
        checkOutput("missCnt", 64'(missCnt), 64'(expMissCnt));
      end
    end
    if (reset) begin
      expQ.delete();
      expHitCnt  = '0;
      expMissCnt = '0;
    end else if (flushStb && !busy) begin
      expHitCnt  = '0;
      expMissCnt = '0;
    end
  end

  task automatic applyStimulus(input logic lk, input logic [VW-1:0] lv, input logic up,
                               input logic [VW-1:0] uv, input logic [PW-1:0] upPpn,
                               input logic iv, input logic [VW-1:0] ivVpn, input logic fl);
    expect_t e;
    int idx;
    @(posedge clock);
    #1;
    lookupStb = lk; lookupVpn = lv;
    updStb = up; updVpn = uv; updPpn = upPpn;
    invStb = iv; invVpn = ivVpn; flushStb = fl;
    if (!reset && !busy) begin
      if (!fl && iv) begin
        idx = int'(ivVpn[IW-1:0]);
        refValid[idx] = 1'b0; refTag[idx] = '0; refPpn[idx] = '0;
      end else if (!fl && up) begin
        idx = int'(uv[IW-1:0]);
        refValid[idx] = 1'b1; refTag[idx] = uv[VW-1:IW]; refPpn[idx] = upPpn;
      end
      if (lk) begin
        idx   = int'(lv[IW-1:0]);
        e.hit = refValid[idx] && (refTag[idx] == lv[VW-1:IW]);
        e.ppn = e.hit ? refPpn[idx] : '0;
        e.cyc = cycleCount;
        expQ.push_back(e);
      end
      if (fl) clearModel();
    end
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic doLookup(input logic [VW-1:0] v);
    applyStimulus(1'b1, v, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic doUpdate(input logic [VW-1:0] v, input logic [PW-1:0] p);
    applyStimulus(1'b0, '0, 1'b1, v, p, 1'b0, '0, 1'b0);
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < 10) begin
      applyIdle();
      n++;
    end
    checkOutput({tag, "Drain"}, 64'(expQ.size()), 64'd0);
  endtask

  task automatic resetDut(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      reset = 1'b1;
      lookupStb = 1'b0; updStb = 1'b0; invStb = 1'b0; flushStb = 1'b0;
      clearModel();
    end
    @(negedge clock);
    checkOutput("rstBusy", 64'(busy), 64'd1);
    checkOutput("rstWe", 64'(ramWe), 64'd0);
    checkOutput("rstWaddr", 64'(ramWaddr), 64'd0);
    checkOutput("rstRaddr", 64'(ramRaddr), 64'd0);
    checkOutput("rstDone", 64'(lookupDone), 64'd0);
    checkOutput("rstCnts", {hitCnt, missCnt}, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Called at the start of the first sweep cycle; walks until busy drops.
  task automatic checkSweep(input string tag);
    int n = 0;
    int bad = 0;
    while (n < 2000) begin
      @(negedge clock);
      if (busy !== 1'b1) break;
      if (ramWe !== 1'b1 || ramWaddr !== IW'(n) || ramWdata !== '0) bad++;
      n++;
      @(posedge clock);
      #1;
    end
    checkOutput({tag, "Len"}, 64'(n), 64'd1024);
    checkOutput({tag, "Seq"}, 64'(bad), 64'd0);
  endtask

  logic [VW-1:0] pool [8];
  logic [VW-1:0] installVpn [4];
  logic [EW-1:0] expData;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0; errorCount = 0; cycleCount = 0;
    expHitCnt = '0; expMissCnt = '0;
    reset = 1'b1;
    lookupStb = 1'b0; updStb = 1'b0; invStb = 1'b0; flushStb = 1'b0;
    lookupVpn = '0; updVpn = '0; updPpn = '0; invVpn = '0;
    pool = '{20'h12345, 20'h00345, 20'h22222, 20'h3F3FF, 20'h003FF, 20'h7A001, 20'h00001, 20'hFFC01};
    installVpn = '{20'h01001, 20'h02002, 20'h03003, 20'h04004};
    clearModel();

    resetDut(3);
    checkSweep("initSweep");

    doLookup(20'h12345);
    waitDrain("coldMiss");
    checkOutput("coldMissCnt", 64'(missCnt), 64'd1);

    doUpdate(20'h12345, 20'hABCDE);
    @(negedge clock);
    expData = {1'b1, 10'h048, 20'hABCDE};
    checkOutput("refillWe", 64'(ramWe), 64'd1);
    checkOutput("refillAddr", 64'(ramWaddr), 64'h345);
    checkOutput("refillData", 64'(ramWdata), 64'(expData));
    doLookup(20'h12345);
    waitDrain("refill");

    doLookup(20'h00345);
    doUpdate(20'h00345, 20'h11111);
    doLookup(20'h12345);
    doLookup(20'h00345);
    waitDrain("alias");

    doLookup(20'h22222);
    applyStimulus(1'b1, 20'h22222, 1'b1, 20'h22222, 20'h00042, 1'b0, '0, 1'b0);
    waitDrain("sameCycle");

    doUpdate(20'h12345, 20'hABCDE);
    doLookup(20'h12345);
    applyStimulus(1'b0, '0, 1'b1, 20'h12345, 20'h55555, 1'b1, 20'h12345, 1'b0);
    @(negedge clock);
    checkOutput("invWe", 64'(ramWe), 64'd1);
    checkOutput("invAddr", 64'(ramWaddr), 64'h345);
    checkOutput("invData", 64'(ramWdata), 64'd0);
    doLookup(20'h12345);
    waitDrain("invWins");

    for (int i = 0; i < 4; i++) doUpdate(installVpn[i], PW'(32'h10000 + i));
    for (int i = 0; i < 3; i++) doLookup(installVpn[i]);
    applyStimulus(1'b1, installVpn[3], 1'b1, 20'h05005, 20'h77777, 1'b0, '0, 1'b1);
    @(negedge clock);
    checkOutput("flushNoWrite", 64'(ramWe), 64'd0);
    applyIdle();
    checkSweep("flushSweep");
    checkOutput("flushHitCnt", 64'(hitCnt), 64'd2);
    checkOutput("flushMissCnt", 64'(missCnt), 64'd0);
    for (int i = 0; i < 4; i++) doLookup(installVpn[i]);
    doLookup(20'h05005);
    waitDrain("postFlush");

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                    1'($urandom_range(0, 3) == 0), pool[$urandom_range(0, 7)], PW'($urandom),
                    1'($urandom_range(0, 7) == 0), pool[$urandom_range(0, 7)], 1'b0);
    end
    waitDrain("random");

    doLookup(20'h22222);
    resetDut(2);
    checkSweep("rstLookupSweep");
    doLookup(20'h22222);
    waitDrain("afterRst");

    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    applyIdle();
    repeat (100) applyIdle();
    @(negedge clock);
    checkOutput("midSweepBusy", 64'(busy), 64'd1);
    checkOutput("midSweepAddr", 64'(ramWaddr), 64'd100);
    resetDut(2);
    checkSweep("restartSweep");
    doLookup(20'h00345);
    waitDrain("final");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
